slot_scan_ctrl: RTL and testbench

Sequencer that drives the 5-bit select of the 25:1 byte multiplexer and consumes its output. On `start` it walks the select through slots 0..24 and waits a programmable settle time at each slot. It then captures the mux output and presents each byte, tagged with its slot index, on a valid/ready stream to the next stage. A one-cycle `done` pulse ends each frame.

---
 rtl/slot_scan_ctrl_if.sv | 29 ++
 rtl/slot_scan_ctrl.sv | 128 ++++++++++++
 tb/tb_slot_scan_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/slot_scan_ctrl_if.sv
// rtl/slot_scan_ctrl_if.sv - output byte stream between the slot sequencer and the next stage
// Purpose: carries one captured mux byte plus its slot index under a valid/ready handshake.
// Ports:
//   out_data  [DATA_W] captured byte           (master -> slave)
//   out_idx   [5]      slot index of out_data  (master -> slave)
//   out_valid          stream valid            (master -> slave)
//   out_ready          stream ready            (slave -> master)
interface slot_scan_ctrl_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] out_data;
  logic [4:0]        out_idx;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_idx,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_idx,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/slot_scan_ctrl.sv
// rtl/slot_scan_ctrl.sv - walks the 25:1 mux select, captures each byte after a settle time, streams it out
// Purpose: on start, steps sel through 0..NUM_SLOTS-1, waits SETTLE_CYCLES at each slot,
//          captures mux_y and offers it with its slot index on a valid/ready stream;
//          a one-cycle done pulse closes the frame.
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           begin a frame (sampled only in IDLE)
//   sel    [5]      select to the mux
//   mux_y  [DATA_W] combinational mux output
//   strm            output stream (out_data, out_idx, out_valid, out_ready)
//   busy            high in SETTLE and OUT
//   done            one-cycle end-of-frame pulse
module slot_scan_ctrl #(
  parameter int NUM_SLOTS     = 25,
  parameter int DATA_W        = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [4:0]        sel,
  input  logic [DATA_W-1:0] mux_y,
  slot_scan_ctrl_if.master  strm,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_OUT    = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [4:0] SLOT_LAST   = 5'(NUM_SLOTS - 1);

  logic [1:0]        state_q, state_d;
  logic [4:0]        sel_q, sel_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [4:0]        idx_q, idx_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETTLE;
          sel_d   = 5'd0;
          cnt_d   = 4'd0;
        end
      end
      ST_SETTLE: begin
        // Capture on the last settle cycle so out_valid rises SETTLE_CYCLES
        // edges after the select changed.
        if (cnt_q == SETTLE_LAST) begin
          data_d  = mux_y;
          idx_d   = sel_q;
          valid_d = 1'b1;
          state_d = ST_OUT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_OUT: begin
        // Held byte stays frozen until accepted; mux_y is not looked at here.
        if (valid_q && strm.out_ready) begin
          valid_d = 1'b0;
          if (sel_q == SLOT_LAST) begin
            sel_d   = 5'd0;
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            sel_d   = sel_q + 5'd1;
            cnt_d   = 4'd0;
            state_d = ST_SETTLE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // busy and done are registered from the next state so they line up with it.
    busy_d = (state_d == ST_SETTLE) || (state_d == ST_OUT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= 5'd0;
      cnt_q   <= 4'd0;
      data_q  <= '0;
      idx_q   <= 5'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sel            = sel_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign strm.out_data  = data_q;
  assign strm.out_idx   = idx_q;
  assign strm.out_valid = valid_q;

endmodule

// File: tb/tb_slot_scan_ctrl.sv
// tb/tb_slot_scan_ctrl.sv - scoreboard bench for slot_scan_ctrl
module tb_slot_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start0, start4;
  logic [4:0] sel0, sel4;
  logic [7:0] mux_y0, mux_y4;
  logic [7:0] perturb;
  logic       busy0, done0, busy4, done4;
  int         checks = 0;
  int         failures = 0;
  int         edge_cnt = 0;
  logic [12:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  slot_scan_ctrl_if #(.DATA_W(8)) if0 ();
  slot_scan_ctrl_if #(.DATA_W(8)) if4 ();

  // Mux models: byte = base + slot, plus a disturbance used during stalls.
  assign mux_y0 = 8'hA0 + {3'b000, sel0} + perturb;
  assign mux_y4 = 8'h30 + {3'b000, sel4};

  slot_scan_ctrl #(.NUM_SLOTS(25), .DATA_W(8), .SETTLE_CYCLES(1)) u_dut (
    .clk(clk), .reset(reset), .start(start0), .sel(sel0), .mux_y(mux_y0),
    .strm(if0.master), .busy(busy0), .done(done0)
  );

  slot_scan_ctrl #(.NUM_SLOTS(25), .DATA_W(8), .SETTLE_CYCLES(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .sel(sel4), .mux_y(mux_y4),
    .strm(if4.master), .busy(busy4), .done(done4)
  );

  task automatic push_frame(input logic [7:0] base);
    for (int i = 0; i < 25; i++) exp_q.push_back({5'(i), base + 8'(i)});
  endtask

  task automatic pulse_start0(output int k);
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    k = edge_cnt;
  endtask

  task automatic test_reset;
    reset = 1'b1; start0 = 1'b0; start4 = 1'b0; perturb = 8'd0;
    if0.out_ready = 1'b0; if4.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({sel0, if0.out_valid, if0.out_data, if0.out_idx, busy0, done0} !== 21'd0) begin
      failures++;
      $display("FAIL reset_dut got=%h exp=0", {sel0, if0.out_valid, if0.out_data, if0.out_idx, busy0, done0});
    end
    checks++;
    if ({sel4, if4.out_valid, if4.out_data, if4.out_idx, busy4, done4} !== 21'd0) begin
      failures++;
      $display("FAIL reset_dut4 got=%h exp=0", {sel4, if4.out_valid, if4.out_data, if4.out_idx, busy4, done4});
    end
  endtask

  task automatic test_basic_frame;
    int k, dcnt;
    logic [12:0] e;
    dcnt = 0;
    push_frame(8'hA0);
    if0.out_ready = 1'b1;
    pulse_start0(k);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done0) begin
        dcnt++;
        checks++;
        if (edge_cnt !== k + 50) begin
          failures++;
          $display("FAIL basic_done_time got=%0d exp=%0d", edge_cnt - k, 50);
        end
      end
      if (if0.out_valid && if0.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL basic_extra_byte got=idx%0d exp=none", if0.out_idx);
        end else begin
          e = exp_q.pop_front();
          if ({if0.out_idx, if0.out_data} !== e) begin
            failures++;
            $display("FAIL basic_byte got=%0d/%h exp=%0d/%h", if0.out_idx, if0.out_data, e[12:8], e[7:0]);
          end
          checks++;
          if (edge_cnt !== k + 1 + 2 * int'(e[12:8])) begin
            failures++;
            $display("FAIL basic_valid_time got=%0d exp=%0d", edge_cnt - k, 1 + 2 * int'(e[12:8]));
          end
        end
      end
    end
    checks++;
    if (dcnt !== 1 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL basic_frame_end got=done%0d left%0d exp=done1 left0", dcnt, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure;
    int k, stall, dcnt;
    logic stalled;
    logic [12:0] e;
    stall = 0; dcnt = 0;
    push_frame(8'hA0);
    if0.out_ready = 1'b1;
    pulse_start0(k);
    for (int c = 0; c < 100 && dcnt == 0; c++) begin
      stalled = 1'b0;
      if (if0.out_valid && if0.out_idx == 5'd3 && stall < 5) begin
        if0.out_ready = 1'b0;
        perturb = perturb + 8'd7;
        stall++;
        stalled = 1'b1;
      end else begin
        if0.out_ready = 1'b1;
        perturb = 8'd0;
      end
      @(negedge clk);
      if (done0) dcnt++;
      if (stalled) begin
        checks++;
        if ({sel0, if0.out_idx, if0.out_data} !== {5'd3, exp_q[0]} || !if0.out_valid) begin
          failures++;
          $display("FAIL bp_frozen got=sel%0d %0d/%h v%0d exp=sel3 %0d/%h v1", sel0, if0.out_idx, if0.out_data, if0.out_valid, exp_q[0][12:8], exp_q[0][7:0]);
        end
      end
      if (if0.out_valid && if0.out_ready) begin
        checks++;
        e = exp_q.pop_front();
        if ({if0.out_idx, if0.out_data} !== e) begin
          failures++;
          $display("FAIL bp_byte got=%0d/%h exp=%0d/%h", if0.out_idx, if0.out_data, e[12:8], e[7:0]);
        end
      end
      @(posedge clk); #1;
    end
    perturb = 8'd0;
    checks++;
    if (stall !== 5 || dcnt !== 1 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL bp_frame_end got=stall%0d done%0d left%0d exp=stall5 done1 left0", stall, dcnt, exp_q.size());
    end
    exp_q.delete();
    repeat (3) @(posedge clk);
  endtask

  task automatic test_settle;
    int k, dcnt, low_run;
    logic prev_valid;
    logic [12:0] e;
    dcnt = 0; low_run = 0; prev_valid = 1'b0;
    push_frame(8'h30);
    if4.out_ready = 1'b1;
    @(posedge clk); #1 start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    k = edge_cnt;
    for (int c = 0; c < 135; c++) begin
      @(negedge clk);
      if (done4) begin
        dcnt++;
        checks++;
        if (edge_cnt !== k + 125) begin
          failures++;
          $display("FAIL settle_frame_len got=%0d exp=125", edge_cnt - k);
        end
      end
      if (if4.out_valid && !prev_valid) begin
        checks++;
        if (edge_cnt !== k + 4 + 5 * int'(if4.out_idx)) begin
          failures++;
          $display("FAIL settle_capture_time got=%0d exp=%0d", edge_cnt - k, 4 + 5 * int'(if4.out_idx));
        end
        if (if4.out_idx != 5'd0) begin
          checks++;
          if (low_run !== 4) begin
            failures++;
            $display("FAIL settle_gap got=%0d exp=4", low_run);
          end
        end
        low_run = 0;
      end
      if (!if4.out_valid) low_run++;
      prev_valid = if4.out_valid;
      if (if4.out_valid && if4.out_ready) begin
        checks++;
        e = exp_q.pop_front();
        if ({if4.out_idx, if4.out_data} !== e) begin
          failures++;
          $display("FAIL settle_byte got=%0d/%h exp=%0d/%h", if4.out_idx, if4.out_data, e[12:8], e[7:0]);
        end
      end
    end
    checks++;
    if (dcnt !== 1 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL settle_frame_end got=done%0d left%0d exp=done1 left0", dcnt, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_start_while_busy;
    int k, dcnt, extra;
    logic pulsed10;
    logic [12:0] e;
    dcnt = 0; extra = 0; pulsed10 = 1'b0;
    push_frame(8'hA0);
    if0.out_ready = 1'b1;
    pulse_start0(k);
    for (int c = 0; c < 60; c++) begin
      start0 = 1'b0;
      if (sel0 == 5'd10 && busy0 && !pulsed10) begin
        start0 = 1'b1;
        pulsed10 = 1'b1;
      end
      if (done0) start0 = 1'b1;
      @(negedge clk);
      if (done0) begin
        dcnt++;
        checks++;
        if (busy0 !== 1'b0) begin
          failures++;
          $display("FAIL swb_busy_in_done got=%0d exp=0", busy0);
        end
      end
      if (if0.out_valid && if0.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL swb_extra_byte got=idx%0d exp=none", if0.out_idx);
        end else begin
          e = exp_q.pop_front();
          if ({if0.out_idx, if0.out_data} !== e) begin
            failures++;
            $display("FAIL swb_byte got=%0d/%h exp=%0d/%h", if0.out_idx, if0.out_data, e[12:8], e[7:0]);
          end
        end
      end
      @(posedge clk); #1;
    end
    start0 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy0 || if0.out_valid || done0) extra++;
    end
    checks++;
    if (dcnt !== 1 || extra !== 0 || exp_q.size() !== 0 || !pulsed10) begin
      failures++;
      $display("FAIL swb_no_second_frame got=done%0d extra%0d left%0d exp=done1 extra0 left0", dcnt, extra, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_frame;
    int k, dcnt;
    logic hit;
    logic [12:0] e;
    dcnt = 0; hit = 1'b0;
    push_frame(8'hA0);
    if0.out_ready = 1'b1;
    pulse_start0(k);
    for (int c = 0; c < 60 && !hit; c++) begin
      if (if0.out_valid && if0.out_idx == 5'd17) begin
        reset = 1'b1;
        if0.out_ready = 1'b0;
        hit = 1'b1;
      end
      @(negedge clk);
      if (if0.out_valid && if0.out_ready) e = exp_q.pop_front();
      if (!hit) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (!hit || {sel0, if0.out_valid, if0.out_data, if0.out_idx, busy0, done0} !== 21'd0) begin
      failures++;
      $display("FAIL rst_mid_state got=hit%0d %h exp=hit1 0", hit, {sel0, if0.out_valid, if0.out_data, if0.out_idx, busy0, done0});
    end
    exp_q.delete();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done0) dcnt++;
    end
    checks++;
    if (dcnt !== 0) begin
      failures++;
      $display("FAIL rst_mid_no_done got=%0d exp=0", dcnt);
    end
    push_frame(8'hA0);
    if0.out_ready = 1'b1;
    pulse_start0(k);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done0) dcnt++;
      if (if0.out_valid && if0.out_ready) begin
        checks++;
        e = exp_q.pop_front();
        if ({if0.out_idx, if0.out_data} !== e) begin
          failures++;
          $display("FAIL rst_mid_refr_byte got=%0d/%h exp=%0d/%h", if0.out_idx, if0.out_data, e[12:8], e[7:0]);
        end
      end
    end
    checks++;
    if (dcnt !== 1 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL rst_mid_refr_end got=done%0d left%0d exp=done1 left0", dcnt, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_random_ready;
    int hs, dcnt, errs;
    logic [12:0] e;
    hs = 0; dcnt = 0; errs = 0;
    for (int f = 0; f < 10; f++) push_frame(8'hA0);
    @(posedge clk); #1;
    start0 = 1'b1;
    for (int c = 0; c < 6000 && dcnt < 10; c++) begin
      if0.out_ready = ($urandom_range(0, 9) < 3);
      if (done0 && dcnt == 9) start0 = 1'b0;
      @(negedge clk);
      if (done0) dcnt++;
      if (if0.out_valid && if0.out_ready) begin
        hs++;
        if (exp_q.size() == 0) begin
          errs++;
        end else begin
          e = exp_q.pop_front();
          checks++;
          if ({if0.out_idx, if0.out_data} !== e) begin
            failures++;
            $display("FAIL rand_byte got=%0d/%h exp=%0d/%h", if0.out_idx, if0.out_data, e[12:8], e[7:0]);
          end
        end
      end
      @(posedge clk); #1;
    end
    start0 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (hs !== 250 || dcnt !== 10 || errs !== 0 || exp_q.size() !== 0 || busy0 !== 1'b0) begin
      failures++;
      $display("FAIL rand_totals got=hs%0d done%0d extra%0d left%0d busy%0d exp=hs250 done10 extra0 left0 busy0", hs, dcnt, errs, exp_q.size(), busy0);
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset;
    test_basic_frame;
    test_backpressure;
    test_settle;
    test_start_while_busy;
    test_reset_mid_frame;
    test_random_ready;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
